// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core/cache interface and the ibus/dbus arbiter state.
// Bus widths, size/length/burst encodings and arbiter enums live here.
package core_bus_arbiter_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // AXI-style length encoding: beats minus one.
    typedef enum logic [7:0] {
        MLEN1  = 8'd0,
        MLEN2  = 8'd1,
        MLEN4  = 8'd3,
        MLEN8  = 8'd7,
        MLEN16 = 8'd15
    } mlen_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'd0,
        AXI_BURST_INCR  = 2'd1,
        AXI_BURST_WRAP  = 2'd2
    } axi_burst_type_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        logic            valid;
        logic            is_write;
        msize_t          size;
        addr_t           addr;
        strobe_t         strobe;
        word_t           data;
        mlen_t           len;
        axi_burst_type_t burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } arb_state_t;

    typedef enum logic {
        OwnerI = 1'b0,
        OwnerD = 1'b1
    } arb_owner_t;

    typedef struct packed {
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
        logic    is_write;
    } arb_txn_t;

    // Instruction fetches return the 32-bit half picked by address bit 2.
    function automatic logic [31:0] select_half(input word_t data, input logic hi);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/core_bus_arbiter.sv
// Merges the core's instruction and data buses onto one single-beat cache-bus master port.
// Transactions are serialised through an Idle/Req/Done FSM with alternating priority.
module core_bus_arbiter
    import core_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    arb_state_t r_state;
    arb_state_t w_state_d;
    arb_owner_t r_owner;
    arb_owner_t w_owner_d;
    logic       r_last_d;
    logic       w_last_d_d;
    arb_txn_t   r_txn;
    arb_txn_t   w_txn_d;
    word_t      r_rdata;
    word_t      w_rdata_d;
    logic       w_grant_d;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_owner  <= OwnerI;
            r_last_d <= 1'b0;
            r_txn    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_owner  <= w_owner_d;
            r_last_d <= w_last_d_d;
            r_txn    <= w_txn_d;
            r_rdata  <= w_rdata_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_owner_d  = r_owner;
        w_last_d_d = r_last_d;
        w_txn_d    = r_txn;
        w_rdata_d  = r_rdata;
        w_grant_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ireq.valid || dreq.valid) begin
                    // D wins ties unless it won the previous grant.
                    w_grant_d  = dreq.valid && !(ireq.valid && r_last_d);
                    w_last_d_d = w_grant_d;
                    w_state_d  = StReq;
                    if (w_grant_d) begin
                        w_owner_d        = OwnerD;
                        w_txn_d.addr     = dreq.addr;
                        w_txn_d.size     = dreq.size;
                        w_txn_d.strobe   = dreq.strobe;
                        w_txn_d.data     = dreq.data;
                        w_txn_d.is_write = |dreq.strobe;
                    end else begin
                        w_owner_d        = OwnerI;
                        w_txn_d.addr     = ireq.addr;
                        w_txn_d.size     = MSIZE4;
                        w_txn_d.strobe   = '0;
                        w_txn_d.data     = '0;
                        w_txn_d.is_write = 1'b0;
                    end
                end
            end
            StReq: begin
                if (oresp.ready && oresp.last) begin
                    w_rdata_d = oresp.data;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                // The requester still holds the completed request, so no grant here.
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        w_done = (r_state == StDone);

        oreq          = '0;
        oreq.valid    = (r_state == StReq);
        oreq.is_write = r_txn.is_write;
        oreq.size     = r_txn.size;
        oreq.addr     = r_txn.addr;
        oreq.strobe   = r_txn.strobe;
        oreq.data     = r_txn.data;
        oreq.len      = MLEN1;
        oreq.burst    = AXI_BURST_FIXED;

        iresp         = '0;
        iresp.addr_ok = w_done && (r_owner == OwnerI);
        iresp.data_ok = w_done && (r_owner == OwnerI);
        iresp.data    = select_half(r_rdata, r_txn.addr[2]);

        dresp         = '0;
        dresp.addr_ok = w_done && (r_owner == OwnerD);
        dresp.data_ok = w_done && (r_owner == OwnerD);
        dresp.data    = r_rdata;
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter: fetch, store, contention, withdrawal, reset, zero-wait.
module tb_core_bus_arbiter;
    import core_bus_arbiter_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int n_checks;
    int n_fail;

    core_bus_arbiter u_dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_data_ok(input string tag, output logic got_i, output logic got_d);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (iresp.data_ok || dresp.data_ok) seen = 1'b1;
        end
        got_i = iresp.data_ok;
        got_d = dresp.data_ok;
        check_eq({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        logic gi;
        logic gd;
        logic exp_d;
        n_checks = 0;
        n_fail   = 0;
        ireq     = '0;
        dreq     = '0;
        oresp    = '0;
        reset    = 1'b1;
        repeat (2) step();

        check_eq("rst_oreq_valid", 64'(oreq.valid), 64'd0);
        check_eq("rst_oreq_addr", oreq.addr, 64'd0);
        check_eq("rst_i_data_ok", 64'(iresp.data_ok), 64'd0);
        check_eq("rst_d_data_ok", 64'(dresp.data_ok), 64'd0);
        check_eq("rst_d_data", dresp.data, 64'd0);
        reset = 1'b0;
        step();

        // Lone fetch, memory answers after a few wait cycles.
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        step();
        check_eq("fetch_oreq_valid", 64'(oreq.valid), 64'd1);
        check_eq("fetch_oreq_addr", oreq.addr, 64'h8000_0004);
        check_eq("fetch_oreq_size", 64'(oreq.size), 64'(MSIZE4));
        check_eq("fetch_oreq_wr", 64'(oreq.is_write), 64'd0);
        check_eq("fetch_oreq_len", 64'(oreq.len), 64'(MLEN1));
        check_eq("fetch_oreq_burst", 64'(oreq.burst), 64'(AXI_BURST_FIXED));
        step();
        check_eq("fetch_no_early_ok", 64'(iresp.data_ok), 64'd0);
        step();
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h1111_2222_3333_4444;
        step();
        check_eq("fetch_i_data_ok", 64'(iresp.data_ok), 64'd1);
        check_eq("fetch_i_addr_ok", 64'(iresp.addr_ok), 64'd1);
        check_eq("fetch_i_data", 64'(iresp.data), 64'h1111_2222);
        check_eq("fetch_d_silent", 64'(dresp.data_ok), 64'd0);
        check_eq("fetch_oreq_drop", 64'(oreq.valid), 64'd0);
        ireq.valid = 1'b0;
        oresp      = '0;
        step();
        check_eq("fetch_ok_one_cycle", 64'(iresp.data_ok), 64'd0);

        // Store held through five wait cycles.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_1000;
        dreq.size   = MSIZE4;
        dreq.strobe = 8'h0F;
        dreq.data   = 64'hDEAD_BEEF;
        step();
        check_eq("store_wr", 64'(oreq.is_write), 64'd1);
        check_eq("store_strobe", 64'(oreq.strobe), 64'h0F);
        check_eq("store_addr", oreq.addr, 64'h8000_1000);
        for (int k = 0; k < 5; k++) begin
            check_eq("store_hold_valid", 64'(oreq.valid), 64'd1);
            check_eq("store_hold_data", oreq.data, 64'hDEAD_BEEF);
            check_eq("store_i_silent", 64'(iresp.data_ok), 64'd0);
            check_eq("store_d_wait", 64'(dresp.data_ok), 64'd0);
            if (k == 2) dreq.data = 64'h0BAD_F00D;
            step();
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h5555_6666_7777_8888;
        step();
        check_eq("store_d_data_ok", 64'(dresp.data_ok), 64'd1);
        check_eq("store_d_data", dresp.data, 64'h5555_6666_7777_8888);
        check_eq("store_i_silent_done", 64'(iresp.data_ok), 64'd0);
        dreq  = '0;
        oresp = '0;
        step();
        check_eq("store_ok_one_cycle", 64'(dresp.data_ok), 64'd0);

        // Contention from reset with zero-wait memory: D, I, D, I, D, I.
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h300;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h408;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'h00;
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h0123_4567_89AB_CDEF;
        reset       = 1'b1;
        step();
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            exp_d = (t % 2 == 0);
            wait_data_ok("cont", gi, gd);
            check_eq("cont_d_owner", 64'(gd), 64'(exp_d));
            check_eq("cont_i_owner", 64'(gi), 64'(!exp_d));
            if (t == 0) check_eq("cont_d_data", dresp.data, 64'h0123_4567_89AB_CDEF);
            if (t == 1) check_eq("cont_i_data", 64'(iresp.data), 64'h89AB_CDEF);
        end
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        step();

        // Address changes during Req; the latched transaction completes first.
        ireq.valid = 1'b1;
        ireq.addr  = 64'h100;
        step();
        check_eq("wd_addr_first", oreq.addr, 64'h100);
        ireq.addr = 64'h200;
        step();
        check_eq("wd_addr_stable", oreq.addr, 64'h100);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        check_eq("wd_i_data_ok", 64'(iresp.data_ok), 64'd1);
        check_eq("wd_i_data", 64'(iresp.data), 64'hCCCC_DDDD);
        oresp = '0;
        step();
        check_eq("wd_idle_gap", 64'(oreq.valid), 64'd0);
        step();
        check_eq("wd_next_valid", 64'(oreq.valid), 64'd1);
        check_eq("wd_next_addr", oreq.addr, 64'h200);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h9999_0000_1234_5678;
        step();
        check_eq("wd_next_ok", 64'(iresp.data_ok), 64'd1);
        check_eq("wd_next_data", 64'(iresp.data), 64'h1234_5678);
        ireq  = '0;
        oresp = '0;
        step();

        // Reset while Req is outstanding.
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h500;
        dreq.size   = MSIZE8;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'h0F0F_0F0F_0F0F_0F0F;
        step();
        check_eq("rr_valid_before", 64'(oreq.valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("rr_valid_after", 64'(oreq.valid), 64'd0);
        check_eq("rr_addr_after", oreq.addr, 64'd0);
        check_eq("rr_d_ok", 64'(dresp.data_ok), 64'd0);
        check_eq("rr_i_ok", 64'(iresp.data_ok), 64'd0);
        check_eq("rr_rdata_cleared", dresp.data, 64'd0);
        step();
        check_eq("rr_regrant_valid", 64'(oreq.valid), 64'd1);
        check_eq("rr_regrant_addr", oreq.addr, 64'h500);
        check_eq("rr_regrant_wr", 64'(oreq.is_write), 64'd1);
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        step();
        check_eq("rr_d_done", 64'(dresp.data_ok), 64'd1);
        dreq  = '0;
        oresp = '0;
        step();

        // Zero-wait cadence: valid t+1, data_ok t+2, idle t+3, valid again t+4.
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h7777_6666_5555_4444;
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h8;
        step();
        check_eq("zw_t1_valid", 64'(oreq.valid), 64'd1);
        check_eq("zw_t1_ok", 64'(iresp.data_ok), 64'd0);
        step();
        check_eq("zw_t2_ok", 64'(iresp.data_ok), 64'd1);
        check_eq("zw_t2_valid", 64'(oreq.valid), 64'd0);
        check_eq("zw_t2_data", 64'(iresp.data), 64'h5555_4444);
        step();
        check_eq("zw_t3_valid", 64'(oreq.valid), 64'd0);
        check_eq("zw_t3_ok", 64'(iresp.data_ok), 64'd0);
        step();
        check_eq("zw_t4_valid", 64'(oreq.valid), 64'd1);
        step();
        check_eq("zw_t5_ok", 64'(iresp.data_ok), 64'd1);
        ireq  = '0;
        oresp = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
# core_bus_arbiter

Memory-side neighbour of `core`. It merges the core's instruction bus (`ireq`/`iresp`) and data bus (`dreq`/`dresp`) onto one cache-bus master port (`oreq`/`oresp`). It serialises single-beat transactions through a three-state FSM and returns completion to the originating requester as a one-cycle `data_ok` pulse. It sits between `core` and the memory/cache subsystem, so the core's fetch-stall and memory-stall logic sees unchanged ibus/dbus semantics.

## Interface
Parameters:
- none; widths come from the `common` package.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ireq`  in  `ibus_req_t`  `valid`, `addr`[63:0].
- `iresp`  out  `ibus_resp_t`  `addr_ok`, `data_ok`, `data`[31:0].
- `dreq`  in  `dbus_req_t`  `valid`, `addr`, `size`, `strobe`[7:0], `data`[63:0].
- `dresp`  out  `dbus_resp_t`  `addr_ok`, `data_ok`, `data`[63:0].
- `oreq`  out  `cbus_req_t`  `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `oresp`  in  `cbus_resp_t`  `ready`, `last`, `data`[63:0].

## Operation
- FSM states: IDLE, REQ, DONE. A 1-bit `owner` (I/D) and a 1-bit `last_d` (last grant was D) are registered alongside.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant D, unless `last_d`=1, in which case grant I. This prevents starvation.
  - Neither valid: stay in IDLE.
  - On a grant, latch the request into `txn` registers, set `owner`, update `last_d`, and go to REQ.
- Latched fields:
  - I grant: `addr` = `ireq.addr`, `size` = MSIZE4, `strobe` = 0, `is_write` = 0.
  - D grant: fields copied from `dreq`; `is_write` = (`dreq.strobe` != 0).
- REQ:
  - `oreq.valid` = 1 and all `oreq` fields are driven from `txn`. They stay stable until completion.
  - `len` = MLEN1 and `burst` = AXI_BURST_FIXED always.
  - `oresp.ready && oresp.last`: latch `oresp.data` into `rdata` and go to DONE.
  - `ready` without `last` cannot occur with `len` = MLEN1; treat it as not yet complete.
- DONE:
  - Assert `addr_ok` = `data_ok` = 1 for `owner` only, for this single cycle.
  - `dresp.data` = `rdata`.
  - `iresp.data` = `rdata`[63:32] if `txn.addr[2]` else `rdata`[31:0].
  - Return to IDLE next cycle. No grant is evaluated in DONE, because the requester still holds the request it just completed.
- Requester withdraws valid or changes addr during REQ: the latched transaction still completes and `data_ok` still pulses. The new value is considered only in IDLE.
- Outputs outside DONE: `addr_ok` = `data_ok` = 0 on both responses. Data outputs always show `rdata` (or its selected half) and are qualified by `data_ok`.

## Timing
- Reset (sampled high at an edge): state = IDLE, `owner` = I, `last_d` = 0, `txn` = 0, `rdata` = 0. All outputs are 0 from that edge onward. This includes `oreq.valid` = 0, even mid-REQ; the memory side is reset by the same signal.
- Minimum latency, with request valid in IDLE at cycle t:
  - t+1: `oreq.valid` = 1.
  - t+1: if `oresp.ready`/`last` also arrive, DONE is entered at t+2.
  - t+2: `data_ok` pulses.
  - t+3: IDLE; the next grant can be sampled.
- Throughput: at most one transaction per 3 cycles plus memory wait cycles.
- `oreq` is purely registered-state driven; there is no combinational path from `ireq`/`dreq` to `oreq`.
- `iresp`/`dresp` depend only on state registers; there is no combinational path from `oresp` to the core.

## Structure
- Add `arb_state_t` (IDLE/REQ/DONE) and `arb_owner_t` (I/D) enums to `common`.
- The `cbus_req_t`/`cbus_resp_t`, MSIZE4, MLEN1 and AXI_BURST_FIXED definitions already live in `common` and are reused.
- Single module, no sub-modules. The FSM, `txn`/`rdata` registers and output muxing fit in about 150–200 lines.
- `core`'s parent instantiates the block between `core` and the memory port.

## Test plan
- **Lone fetch.** Stimulus: `ireq` valid, addr 0x8000_0004; `oresp` ready at t+3 with data 0x1111_2222_3333_4444. Required: `oreq` shows addr 0x8000_0004, `size` MSIZE4, `is_write` 0; `iresp.data_ok` pulses one cycle with data 0x1111_2222.
- **Store.** Stimulus: `dreq` valid, addr 0x8000_1000, strobe 0x0F, data 0xDEAD_BEEF. Required: `oreq.is_write` = 1, strobe 0x0F, data held stable across 5 wait cycles; `dresp.data_ok` pulses once; `iresp` stays silent.
- **Contention.** Stimulus: `ireq` and `dreq` both continuously valid from reset. Required: grants alternate D, I, D, I…, checked over 6 transactions; no two consecutive `data_ok` pulses go to the same owner.
- **Withdrawal mid-REQ.** Stimulus: `ireq` changes addr 0x100→0x200 during REQ. Required: `oreq.addr` stays 0x100 and `iresp.data_ok` still pulses; the next transaction uses 0x200.
- **Reset mid-REQ.** Stimulus: assert `reset` for one cycle while in REQ with `oreq.valid` = 1. Required: `oreq.valid` = 0 and both `data_ok` = 0 from that edge; the FSM is in IDLE and a new request is granted normally afterwards.
- **Zero-wait memory.** Stimulus: `oresp.ready` = `last` = 1 permanently. Required: the exact 3-cycle cadence (`oreq.valid` t+1, `data_ok` t+2, next `oreq.valid` t+4).
